// File: rtl/fp_div_stream.sv
// Streaming fp32 divider q = a * inv(b). Latency 10 cycles from accept to out_valid; never stalls inside.
// Backpressure via credits on a FWFT output FIFO. Optional FP_DIV_ZERO_FLAG_EN adds out_div_zero.
module fp_inv (
  input  logic        clk,
  input  logic [31:0] b_i,
  output logic [31:0] r_o
);
  // Linear seed 2.9142 - 2d for 1/d, d in [0.5,1), Q2.23; three NR steps follow.
  localparam logic [24:0] X0_K = 25'd24446082;
  localparam logic [24:0] TWO  = 25'h1000000;

  logic [8:0]        se_q [7];
  logic [23:0]       d_q  [5];
  logic [24:0]       x_q  [4];
  logic [24:0]       xt_q [3];
  logic [24:0]       t_q  [3];
  logic [31:0]       r_d, r_q;
  logic signed [9:0] re;
  logic [22:0]       fr;
  logic [7:0]        e;

  always_ff @(posedge clk) begin
    se_q[0] <= b_i[31:23];
    d_q[0]  <= {1'b1, b_i[22:0]};
    x_q[0]  <= X0_K - {1'b0, 1'b1, b_i[22:0]};
    for (int i = 1; i < 7; i++) se_q[i] <= se_q[i-1];
    for (int i = 1; i < 5; i++) d_q[i] <= d_q[i-1];
    for (int i = 0; i < 3; i++) begin
      t_q[i]   <= 25'(({25'b0, d_q[2*i]} * {24'b0, x_q[i]}) >> 24);
      xt_q[i]  <= x_q[i];
      x_q[i+1] <= 25'(({25'b0, xt_q[i]} * {25'b0, TWO - t_q[i]}) >> 23);
    end
    r_q <= r_d;
  end

  always_comb begin
    e  = se_q[6][7:0];
    re = 10'sd253 - $signed({2'b0, e});
    fr = '0;
    if (x_q[3][24]) begin
      re = 10'sd254 - $signed({2'b0, e});
      fr = x_q[3][23:1];
    end else if (x_q[3][23]) begin
      fr = x_q[3][22:0];
    end
    if (e == 8'd0)          r_d = {se_q[6][8], 8'hff, 23'd0};
    else if (re <= 10'sd0)  r_d = {se_q[6][8], 31'd0};
    else                    r_d = {se_q[6][8], re[7:0], fr};
  end

  assign r_o = r_q;
endmodule

module fp_mul #(
  parameter int DELAY = 1
) (
  input  logic        clk,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  logic [31:0]       p_d;
  logic [31:0]       pipe_q [DELAY];
  logic [24:0]       ph;
  logic signed [9:0] re;
  logic [22:0]       fr;
  logic              sgn;

  always_comb begin
    sgn = a_i[31] ^ b_i[31];
    ph  = 25'(({24'b0, 1'b1, a_i[22:0]} * {24'b0, 1'b1, b_i[22:0]}) >> 23);
    re  = $signed({2'b0, a_i[30:23]}) + $signed({2'b0, b_i[30:23]}) - 10'sd127
          + (ph[24] ? 10'sd1 : 10'sd0);
    fr  = ph[24] ? ph[23:1] : ph[22:0];
    if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0)
      p_d = {sgn, 31'd0};
    else if (a_i[30:23] == 8'hff || b_i[30:23] == 8'hff || re >= 10'sd255)
      p_d = {sgn, 8'hff, 23'd0};
    else if (re <= 10'sd0)
      p_d = {sgn, 31'd0};
    else
      p_d = {sgn, re[7:0], fr};
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= p_d;
    for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign p_o = pipe_q[DELAY-1];
endmodule

module fp_div_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         head_vld,
  output logic [W-1:0] head_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign head_vld = (cnt_q != '0);
  assign do_pop   = pop_rdy && head_vld;
  // Gate the head so an empty FIFO presents zeros without resetting storage.
  assign head_dat = head_vld ? mem_q[rd_q] : '0;

  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_vld) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)   rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_vld) - CW'(do_pop);
    end
  end
endmodule

module fp_div_stream #(
  parameter int TAG_W      = 8,
  parameter int MUL_DELAY  = 1,
  parameter int FIFO_DEPTH = 16,
  localparam int FP_BITS   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FP_BITS-1:0] in_a,
  input  logic [FP_BITS-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_BITS-1:0] out_q,
  output logic [TAG_W-1:0]   out_tag
`ifdef FP_DIV_ZERO_FLAG_EN
  ,
  output logic               out_div_zero
`endif
);
  localparam int INV_DELAY = 8;
  localparam int DIV_DELAY = INV_DELAY + MUL_DELAY;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
`ifdef FP_DIV_ZERO_FLAG_EN
  localparam int FW = FP_BITS + TAG_W + 1;
`else
  localparam int FW = FP_BITS + TAG_W;
`endif

  logic                 accept, pop, fifo_vld;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DIV_DELAY-1:0] vld_q;
  logic [TAG_W-1:0]     tag_q [DIV_DELAY];
  logic [FP_BITS-1:0]   a_q   [INV_DELAY];
  logic [FP_BITS-1:0]   inv_b, q_raw;
  logic [FW-1:0]        push_dat, head_dat;

  // Credits cover in-flight plus buffered results, so the FIFO can never overflow.
  assign in_ready = (cnt_q < CW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = fifo_vld && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= {vld_q[DIV_DELAY-2:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    a_q[0]   <= in_a;
    tag_q[0] <= in_tag;
    for (int i = 1; i < INV_DELAY; i++) a_q[i] <= a_q[i-1];
    for (int i = 1; i < DIV_DELAY; i++) tag_q[i] <= tag_q[i-1];
  end

  fp_inv u_inv (
    .clk (clk),
    .b_i (in_b),
    .r_o (inv_b)
  );

  fp_mul #(.DELAY(MUL_DELAY)) u_mul (
    .clk (clk),
    .a_i (a_q[INV_DELAY-1]),
    .b_i (inv_b),
    .p_o (q_raw)
  );

`ifdef FP_DIV_ZERO_FLAG_EN
  logic [DIV_DELAY-1:0] zero_q, zsgn_q;

  always_ff @(posedge clk) begin
    zero_q <= {zero_q[DIV_DELAY-2:0], (in_b[FP_BITS-2:0] == '0)};
    zsgn_q <= {zsgn_q[DIV_DELAY-2:0], in_a[FP_BITS-1] ^ in_b[FP_BITS-1]};
  end

  assign push_dat = {zero_q[DIV_DELAY-1],
                     zero_q[DIV_DELAY-1] ? {zsgn_q[DIV_DELAY-1], {(FP_BITS-1){1'b1}}} : q_raw,
                     tag_q[DIV_DELAY-1]};
  assign out_div_zero = head_dat[FW-1];
`else
  assign push_dat = {q_raw, tag_q[DIV_DELAY-1]};
`endif

  fp_div_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (vld_q[DIV_DELAY-1]),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .head_vld (fifo_vld),
    .head_dat (head_dat)
  );

  assign out_valid        = fifo_vld;
  assign {out_q, out_tag} = head_dat[FP_BITS+TAG_W-1:0];
endmodule

// File: tb/tb_fp_div_stream.sv
// Directed bench for fp_div_stream: latency, streaming, credits, reset flush, optional zero flag.
module tb_fp_div_stream;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_q;
  logic [7:0]  in_tag, out_tag;
`ifdef FP_DIV_ZERO_FLAG_EN
  logic        out_div_zero;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc, acc_cyc, stalls, nxt, steady;

  logic [31:0] mq[$];
  logic [7:0]  mt[$];
  int          mc[$];
  logic        mz[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_div_stream #(.TAG_W(8), .MUL_DELAY(1), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_tag   (out_tag)
`ifdef FP_DIV_ZERO_FLAG_EN
    ,
    .out_div_zero (out_div_zero)
`endif
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mq.push_back(out_q);
      mt.push_back(out_tag);
      mc.push_back(cyc);
`ifdef FP_DIV_ZERO_FLAG_EN
      mz.push_back(out_div_zero);
`else
      mz.push_back(1'b0);
`endif
    end
    if (!rst && in_valid && in_ready) begin
      n_acc++;
      acc_cyc = cyc;
    end
    if (in_valid && !in_ready) stalls++;
  end

  task automatic chk(input string tag, input real obs, input real exp, input real tol);
    total++;
    if ((obs > exp ? obs - exp : exp - obs) > tol) begin
      bad++;
      $display("FAIL %s: got %g, want %g (tol %g)", tag, obs, exp, tol);
    end
  endtask

  function automatic logic [31:0] i2f(input int n);
    int p = 0;
    for (int i = 0; i < 24; i++) if (n >= (1 << i)) p = i;
    return {1'b0, 8'(127 + p), 23'((n << (23 - p)) & 32'h7fffff)};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    mq.delete(); mt.delete(); mc.delete(); mz.delete();
    n_acc = 0; stalls = 0; nxt = 0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] t);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    tick();
    in_valid = 1'b0;
  endtask

  // Holds in_valid for ncyc cycles; operand index advances only on accept.
  task automatic feed(input int ncyc, input logic [31:0] b);
    for (int i = 0; i < ncyc; i++) begin
      in_valid = 1'b1; in_a = i2f(nxt + 1); in_b = b; in_tag = 8'(nxt);
      @(negedge clk);
      if (in_ready) nxt++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_tag = '0;
    clr();
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", real'(in_ready), 1.0, 0.0);
    chk("rst_out_valid", real'(out_valid), 0.0, 0.0);
    chk("rst_out_q", real'(out_q), 0.0, 0.0);
    chk("rst_out_tag", real'(out_tag), 0.0, 0.0);
    tick();

    // single op 6/2
    clr();
    send(32'h40C00000, 32'h40000000, 8'h11);
    idle(20);
    chk("t1_count", real'(mq.size()), 1.0, 0.0);
    if (mq.size() > 0) begin
      chk("t1_q", f2r(mq[0]), 3.0, 3.0 / 1024.0);
      chk("t1_tag", real'(mt[0]), 17.0, 0.0);
      chk("t1_latency", real'(mc[0] - acc_cyc), 10.0, 0.0);
    end

    // 32 back-to-back, b=0.5
    clr();
    feed(32, 32'h3F000000);
    idle(20);
    chk("t2_stalls", real'(stalls), 0.0, 0.0);
    chk("t2_acc", real'(n_acc), 32.0, 0.0);
    chk("t2_count", real'(mq.size()), 32.0, 0.0);
    for (int i = 0; i < mq.size(); i++) begin
      chk("t2_tag", real'(mt[i]), real'(i), 0.0);
      chk("t2_q", f2r(mq[i]), 2.0 * (i + 1), 2.0 * (i + 1) / 1024.0);
    end
    if (mq.size() == 32) chk("t2_gapless", real'(mc[31] - mc[0]), 31.0, 0.0);

    // backpressure fills exactly FIFO_DEPTH credits
    out_ready = 1'b0;
    clr();
    feed(30, 32'h3F800000);
    chk("t3_acc", real'(n_acc), 16.0, 0.0);
    @(negedge clk);
    chk("t3_full_ready", real'(in_ready), 0.0, 0.0);
    chk("t3_full_valid", real'(out_valid), 1.0, 0.0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready_at_pop", real'(in_ready), 0.0, 0.0);
    tick();
    @(negedge clk);
    chk("t3_ready_after_pop", real'(in_ready), 1.0, 0.0);
    tick();
    idle(20);
    chk("t3_count", real'(mq.size()), 16.0, 0.0);
    for (int i = 0; i < mq.size(); i++) begin
      chk("t3_tag", real'(mt[i]), real'(i), 0.0);
      chk("t3_q", f2r(mq[i]), real'(i + 1), real'(i + 1) / 1024.0);
    end

    // full credits, then accept and pop together
    out_ready = 1'b0;
    clr();
    feed(25, 32'h3F800000);
    out_ready = 1'b1;
    steady = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; in_a = i2f(nxt + 1); in_b = 32'h3F800000; in_tag = 8'(nxt);
      @(negedge clk);
      if (i >= 25 && in_ready && out_valid) steady++;
      if (in_ready) nxt++;
      tick();
    end
    in_valid = 1'b0;
    idle(25);
    chk("t4_steady", real'(steady), 35.0, 0.0);
    chk("t4_acc", real'(n_acc), 75.0, 0.0);
    chk("t4_count", real'(mq.size()), 75.0, 0.0);
    for (int i = 0; i < mq.size(); i++) chk("t4_tag", real'(mt[i]), real'(i % 256), 0.0);

    // reset with 3 buffered and 5 in flight
    out_ready = 1'b0;
    clr();
    feed(3, 32'h40000000);
    idle(12);
    feed(5, 32'h40000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    idle(25);
    chk("t5_no_stale", real'(mq.size()), 0.0, 0.0);
    @(negedge clk);
    chk("t5_out_valid", real'(out_valid), 0.0, 0.0);
    chk("t5_in_ready", real'(in_ready), 1.0, 0.0);
    tick();
    clr();
    send(32'h3F800000, 32'h40800000, 8'h5A);
    idle(15);
    chk("t5_count", real'(mq.size()), 1.0, 0.0);
    if (mq.size() > 0) begin
      chk("t5_q", f2r(mq[0]), 0.25, 0.25 / 1024.0);
      chk("t5_tag", real'(mt[0]), 90.0, 0.0);
    end

`ifdef FP_DIV_ZERO_FLAG_EN
    clr();
    send(32'hC0400000, 32'h00000000, 8'h21);
    send(32'h3F800000, 32'h3F800000, 8'h22);
    idle(15);
    chk("t6_count", real'(mq.size()), 2.0, 0.0);
    if (mq.size() == 2) begin
      chk("t6_zero_flag", real'(mz[0]), 1.0, 0.0);
      chk("t6_zero_q", real'(mq[0]), 4294967295.0, 0.0);
      chk("t6_one_flag", real'(mz[1]), 0.0, 0.0);
      chk("t6_one_q", f2r(mq[1]), 1.0, 1.0 / 1024.0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
